// File: rtl/tlp_length_tracker_pkg.sv
// Shared PCIe MAC definitions for the TLP length tracker slice.
//   - link generation encodings (Gen3/4/5)
//   - default geometry: NUM_BYTES, MAX_PKTS and LEN_W
//   - gen_supported(): true for generations that carry framed TLPs
package pcie_mac_pkg;

  localparam int unsigned DEF_NUM_BYTES = 64;
  localparam int unsigned DEF_MAX_PKTS  = 16;
  localparam int unsigned DEF_LEN_W     = 11;

  typedef enum logic [2:0] {
    GEN3 = 3'b011,
    GEN4 = 3'b100,
    GEN5 = 3'b101
  } gen_e;

  function automatic logic gen_supported(input logic [2:0] gen);
    return (gen == GEN3) || (gen == GEN4) || (gen == GEN5);
  endfunction

endpackage

// File: rtl/tlp_length_tracker_if.sv
// Beat bus of the TLP length tracker.
//   Inputs to the tracker : gen, data_in, wr, wr_valid, STP_IN, SDP_IN, END_IN
//   Outputs of the tracker: data_out, wr_out, wr_valid_out, STP_out, SDP_out,
//                           END_out, length, length_valid, len_ovf,
//                           carry_active, drop_err, end_err, abort_err
// master = beat source / result sink, slave = the tracker.
interface tlp_length_tracker_if
  import pcie_mac_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned MAX_PKTS  = DEF_MAX_PKTS,
  parameter int unsigned LEN_W     = DEF_LEN_W
);

  logic [2:0]                gen;
  logic [8*NUM_BYTES-1:0]    data_in;
  logic                      wr;
  logic [NUM_BYTES-1:0]      wr_valid;
  logic [NUM_BYTES-1:0]      STP_IN;
  logic [NUM_BYTES-1:0]      SDP_IN;
  logic [NUM_BYTES-1:0]      END_IN;

  logic [8*NUM_BYTES-1:0]    data_out;
  logic                      wr_out;
  logic [NUM_BYTES-1:0]      wr_valid_out;
  logic [NUM_BYTES-1:0]      STP_out;
  logic [NUM_BYTES-1:0]      SDP_out;
  logic [NUM_BYTES-1:0]      END_out;
  logic [MAX_PKTS*LEN_W-1:0] length;
  logic [MAX_PKTS-1:0]       length_valid;
  logic [MAX_PKTS-1:0]       len_ovf;
  logic                      carry_active;
  logic                      drop_err;
  logic                      end_err;
  logic                      abort_err;

  modport master (
    output gen, data_in, wr, wr_valid, STP_IN, SDP_IN, END_IN,
    input  data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out,
           length, length_valid, len_ovf, carry_active,
           drop_err, end_err, abort_err
  );

  modport slave (
    input  gen, data_in, wr, wr_valid, STP_IN, SDP_IN, END_IN,
    output data_out, wr_out, wr_valid_out, STP_out, SDP_out, END_out,
           length, length_valid, len_ovf, carry_active,
           drop_err, end_err, abort_err
  );

endinterface

// File: rtl/tlp_length_tracker_scan.sv
// tlp_len_scan: combinational scan of one beat, byte 0 upward.
//   wr_valid_i/stp_i/end_i : per-byte valid and framing markers
//   carry_*_i              : TLP state carried in from the previous beat
//   length_o/length_valid_o/len_ovf_o : per-slot results of TLPs closed here
//   carry_*_o              : TLP state left open at the end of this beat
//   drop_err_o/end_err_o/abort_err_o  : framing errors seen in this beat
module tlp_len_scan
  import pcie_mac_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned MAX_PKTS  = DEF_MAX_PKTS,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  localparam int unsigned CNT_W    = LEN_W + 2
) (
  input  logic [NUM_BYTES-1:0]      wr_valid_i,
  input  logic [NUM_BYTES-1:0]      stp_i,
  input  logic [NUM_BYTES-1:0]      end_i,
  input  logic                      carry_open_i,
  input  logic [CNT_W-1:0]          carry_cnt_i,
  input  logic                      carry_ovf_i,
  output logic [MAX_PKTS*LEN_W-1:0] length_o,
  output logic [MAX_PKTS-1:0]       length_valid_o,
  output logic [MAX_PKTS-1:0]       len_ovf_o,
  output logic                      carry_open_o,
  output logic [CNT_W-1:0]          carry_cnt_o,
  output logic                      carry_ovf_o,
  output logic                      drop_err_o,
  output logic                      end_err_o,
  output logic                      abort_err_o
);

  // Largest byte count whose DW length still fits in LEN_W bits.
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(4 * ((2 ** LEN_W) - 1));

  logic             open;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             close;
  logic [CNT_W-1:0] rounded;
  logic [LEN_W-1:0] dw_len;
  // One-hot pointer to the next free slot; the top bit means "all slots used".
  logic [MAX_PKTS:0] slot;

  always_comb begin
    open           = carry_open_i;
    cnt            = carry_cnt_i;
    ovf            = carry_ovf_i;
    close          = 1'b0;
    rounded        = '0;
    dw_len         = '0;
    slot           = '0;
    slot[0]        = 1'b1;
    length_o       = '0;
    length_valid_o = '0;
    len_ovf_o      = '0;
    drop_err_o     = 1'b0;
    end_err_o      = 1'b0;
    abort_err_o    = 1'b0;

    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      close = 1'b0;
      if (wr_valid_i[i]) begin
        if (stp_i[i]) begin
          if (open) abort_err_o = 1'b1;
          open  = 1'b1;
          cnt   = CNT_W'(1);
          ovf   = 1'b0;
          close = end_i[i];
        end else if (open) begin
          // Count freezes at MAX_BYTES; ovf remembers that bytes were lost.
          if (cnt == MAX_BYTES) ovf = 1'b1;
          else                  cnt = cnt + CNT_W'(1);
          close = end_i[i];
        end else if (end_i[i]) begin
          end_err_o = 1'b1;
        end
      end

      if (close) begin
        rounded = cnt + CNT_W'(3);
        dw_len  = ovf ? '1 : rounded[CNT_W-1:2];
        if (slot[MAX_PKTS]) begin
          drop_err_o = 1'b1;
        end else begin
          for (int unsigned k = 0; k < MAX_PKTS; k++) begin
            if (slot[k]) begin
              length_o[k*LEN_W +: LEN_W] = dw_len;
              length_valid_o[k]          = 1'b1;
              len_ovf_o[k]               = ovf;
            end
          end
          slot = slot << 1;
        end
        open = 1'b0;
        cnt  = '0;
        ovf  = 1'b0;
      end
    end

    carry_open_o = open;
    carry_cnt_o  = cnt;
    carry_ovf_o  = ovf;
  end

endmodule

// File: rtl/tlp_length_tracker.sv
// tlp_length_tracker: reports DW lengths of TLPs framed by STP/END markers.
//   pclk, reset_n : clock and synchronous active-low reset
//   bus (slave)   : beat inputs (gen, data_in, wr, wr_valid, STP_IN, SDP_IN,
//                   END_IN) and their one-cycle-delayed copies plus per-slot
//                   lengths, valid/overflow flags, carry_active and error
//                   pulses, all registered so they line up with data_out.
module tlp_length_tracker
  import pcie_mac_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEF_NUM_BYTES,
  parameter int unsigned MAX_PKTS  = DEF_MAX_PKTS,
  parameter int unsigned LEN_W     = DEF_LEN_W
) (
  input logic                 pclk,
  input logic                 reset_n,
  tlp_length_tracker_if.slave bus
);

  localparam int unsigned CNT_W = LEN_W + 2;

  logic                      gen_ok;

  logic [MAX_PKTS*LEN_W-1:0] scan_length;
  logic [MAX_PKTS-1:0]       scan_valid;
  logic [MAX_PKTS-1:0]       scan_ovf;
  logic                      scan_open;
  logic [CNT_W-1:0]          scan_cnt;
  logic                      scan_cnt_ovf;
  logic                      scan_drop;
  logic                      scan_end;
  logic                      scan_abort;

  logic [8*NUM_BYTES-1:0]    data_q;
  logic                      wr_q;
  logic [NUM_BYTES-1:0]      wr_valid_q, stp_q, sdp_q, end_q;

  logic [MAX_PKTS*LEN_W-1:0] length_q, length_d;
  logic [MAX_PKTS-1:0]       length_valid_q, length_valid_d;
  logic [MAX_PKTS-1:0]       len_ovf_q, len_ovf_d;
  logic                      drop_err_q, drop_err_d;
  logic                      end_err_q, end_err_d;
  logic                      abort_err_q, abort_err_d;
  logic                      carry_open_q, carry_open_d;
  logic [CNT_W-1:0]          carry_cnt_q, carry_cnt_d;
  logic                      carry_ovf_q, carry_ovf_d;

  assign gen_ok = gen_supported(bus.gen);

  tlp_len_scan #(
    .NUM_BYTES (NUM_BYTES),
    .MAX_PKTS  (MAX_PKTS),
    .LEN_W     (LEN_W)
  ) u_scan (
    .wr_valid_i     (bus.wr_valid),
    .stp_i          (bus.STP_IN),
    .end_i          (bus.END_IN),
    .carry_open_i   (carry_open_q),
    .carry_cnt_i    (carry_cnt_q),
    .carry_ovf_i    (carry_ovf_q),
    .length_o       (scan_length),
    .length_valid_o (scan_valid),
    .len_ovf_o      (scan_ovf),
    .carry_open_o   (scan_open),
    .carry_cnt_o    (scan_cnt),
    .carry_ovf_o    (scan_cnt_ovf),
    .drop_err_o     (scan_drop),
    .end_err_o      (scan_end),
    .abort_err_o    (scan_abort)
  );

  // Idle beats hold the carry; unsupported generations drop it.
  always_comb begin
    length_d       = '0;
    length_valid_d = '0;
    len_ovf_d      = '0;
    drop_err_d     = 1'b0;
    end_err_d      = 1'b0;
    abort_err_d    = 1'b0;
    carry_open_d   = carry_open_q;
    carry_cnt_d    = carry_cnt_q;
    carry_ovf_d    = carry_ovf_q;

    if (!gen_ok) begin
      carry_open_d = 1'b0;
      carry_cnt_d  = '0;
      carry_ovf_d  = 1'b0;
    end else if (bus.wr) begin
      length_d       = scan_length;
      length_valid_d = scan_valid;
      len_ovf_d      = scan_ovf;
      drop_err_d     = scan_drop;
      end_err_d      = scan_end;
      abort_err_d    = scan_abort;
      carry_open_d   = scan_open;
      carry_cnt_d    = scan_cnt;
      carry_ovf_d    = scan_cnt_ovf;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      data_q         <= '0;
      wr_q           <= 1'b0;
      wr_valid_q     <= '0;
      stp_q          <= '0;
      sdp_q          <= '0;
      end_q          <= '0;
      length_q       <= '0;
      length_valid_q <= '0;
      len_ovf_q      <= '0;
      drop_err_q     <= 1'b0;
      end_err_q      <= 1'b0;
      abort_err_q    <= 1'b0;
      carry_open_q   <= 1'b0;
      carry_cnt_q    <= '0;
      carry_ovf_q    <= 1'b0;
    end else begin
      data_q         <= bus.data_in;
      wr_q           <= bus.wr;
      wr_valid_q     <= bus.wr_valid;
      stp_q          <= bus.STP_IN;
      sdp_q          <= bus.SDP_IN;
      end_q          <= bus.END_IN;
      length_q       <= length_d;
      length_valid_q <= length_valid_d;
      len_ovf_q      <= len_ovf_d;
      drop_err_q     <= drop_err_d;
      end_err_q      <= end_err_d;
      abort_err_q    <= abort_err_d;
      carry_open_q   <= carry_open_d;
      carry_cnt_q    <= carry_cnt_d;
      carry_ovf_q    <= carry_ovf_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.wr_out       = wr_q;
  assign bus.wr_valid_out = wr_valid_q;
  assign bus.STP_out      = stp_q;
  assign bus.SDP_out      = sdp_q;
  assign bus.END_out      = end_q;
  assign bus.length       = length_q;
  assign bus.length_valid = length_valid_q;
  assign bus.len_ovf      = len_ovf_q;
  assign bus.carry_active = carry_open_q;
  assign bus.drop_err     = drop_err_q;
  assign bus.end_err      = end_err_q;
  assign bus.abort_err    = abort_err_q;

endmodule

// File: doc/tlp_length_tracker.md
TLP_LENGTH_TRACKER -- requirements
Module: tlp_length_tracker

Interface
REQ-001 The block SHALL take parameter NUM_BYTES, default 64: symbol bytes per beat.
REQ-002 The block SHALL take parameter MAX_PKTS, default 16: length slots reported per beat.
REQ-003 The block SHALL take parameter LEN_W, default 11: width of one length field, in DW.
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port gen, input, 3 bits: link generation (3'b011/3'b100/3'b101 = Gen3/4/5).
REQ-007 The block SHALL have port data_in, input, 8*NUM_BYTES bits: beat payload.
REQ-008 The block SHALL have port wr, input, 1 bit: beat valid.
REQ-009 The block SHALL have ports wr_valid, STP_IN, SDP_IN and END_IN, each input, NUM_BYTES bits: per-byte valid, STP, SDP and END markers.
REQ-010 The block SHALL have ports data_out, wr_out, wr_valid_out, STP_out, SDP_out and END_out, outputs matching their input widths: copies of the inputs delayed one cycle.
REQ-011 The block SHALL have port length, output, MAX_PKTS*LEN_W bits: slot k occupies bits [k*LEN_W +: LEN_W].
REQ-012 The block SHALL have port length_valid, output, MAX_PKTS bits: bit k set means slot k holds a completed TLP.
REQ-013 The block SHALL have port len_ovf, output, MAX_PKTS bits: slot k length saturated.
REQ-014 The block SHALL have port carry_active, output, 1 bit: a TLP is open across the beat boundary.
REQ-015 The block SHALL have ports drop_err, end_err and abort_err, outputs, 1 bit each: per-beat error pulses.

Function
REQ-016 The block SHALL register all outputs, with latency exactly 1 cycle, so that length, length_valid and the errors align with data_out.
REQ-017 The block SHALL scan bytes from 0 to NUM_BYTES-1 in a beat with wr=1, counting only bytes with wr_valid=1.
REQ-018 An STP byte SHALL open a TLP, with the byte count starting at 1 and including the STP byte.
REQ-019 An END byte SHALL close the open TLP, counting the END byte, and report length = ceil(bytes/4) in DW.
REQ-020 An open TLP SHALL carry its byte count in a register across beats; carry_active SHALL be 1 while it is open at the end of a beat.
REQ-021 In a beat with wr=0, the block SHALL keep the carry register, set length_valid=0, set wr_out=0 and raise no error.
REQ-022 The j-th TLP closed in a beat (j from 0) SHALL go to slot j; unused slots SHALL read length 0 and valid 0.
REQ-023 If more than MAX_PKTS TLPs close in one beat, the extra ones SHALL be discarded and drop_err=1.
REQ-024 An END with no open TLP SHALL be ignored and set end_err=1.
REQ-025 An STP while a TLP is open SHALL discard the open count, restart the count at 1, and set abort_err=1.
REQ-026 STP and END on the same byte SHALL give length 1.
REQ-027 A byte count that would exceed 4*(2^LEN_W-1) SHALL saturate, and the slot SHALL report 2^LEN_W-1 with len_ovf set.
REQ-028 SDP bytes SHALL not open or close a TLP; SDP_IN is passed through only.
REQ-029 For gen outside Gen3-5, the block SHALL pass data through, force length, length_valid and the errors to 0, and clear the carry register.

Reset
REQ-030 When reset_n=0 at a pclk edge, the block SHALL set every output and the carry register to 0, overriding in-flight beats.
REQ-031 A TLP open at reset SHALL be lost; an END arriving after reset SHALL raise end_err.

Structure
REQ-032 A shared package pcie_mac_pkg SHALL hold the GEN3/GEN4/GEN5 encodings and the NUM_BYTES, MAX_PKTS and LEN_W defaults.
REQ-033 The combinational per-beat scan SHALL be the sub-module tlp_len_scan; the top level holds the carry register and the output registers.

Verification (defaults, gen=3'b011, all wr_valid=1)
REQ-034 Scenario: STP at byte 0, END at byte 15 -> next cycle slot0=4, length_valid=16'h0001.
REQ-035 Scenario: STP at byte 48 in beat A, END at byte 11 in beat B -> after A, length_valid=0 and carry_active=1; after B, slot0=7 and carry_active=0.
REQ-036 Scenario: 17 two-byte TLPs in one beat -> slots 0..15 equal 1, length_valid=16'hFFFF, drop_err=1.
REQ-037 Scenario: a wr=0 beat inserted mid-TLP in the previous scenario -> slot0 is still 7 and no error is raised.
REQ-038 Scenario: gen=3'b010 with STP/END present -> length_valid=0, and data_out equals data_in delayed one cycle.
REQ-039 Scenario: reset_n=0 with a TLP open, then a beat with only END at byte 3 -> end_err=1, length_valid=0.
